axi_rd_monitor: RTL
===================

# axi_rd_monitor

Synthesizable, parametrised AXI4-Lite read-path protocol monitor covering both the AR and R channels. It generalises the read-data assertion checks into RTL that can run in silicon or emulation. It tracks outstanding reads and reports each rule violation as a one-cycle pulse, a sticky flag and a first-error code, and keeps completion and error-response counters. It sits passively on the bus between master and slave, drives nothing onto the bus, and feeds the debug/status register block.

## Interface
- MAXWAIT, 5, max cycles RVALID may stall with RREADY low before flagging (≥1)
- MAX_OUTSTANDING, 4, max accepted-but-unanswered reads (≥1)
- C_AXI_DATA_WIDTH, 32, RDATA width
- C_AXI_ADDR_WIDTH, 8, ARADDR width
- AXI_ACLK  in  1  clock; all logic on rising edge
- AXI_ARESETN  in  1  synchronous active-low reset
- AXI_ARADDR  in  C_AXI_ADDR_WIDTH  read address
- AXI_ARPROT  in  3  protection attributes
- AXI_ARVALID / AXI_ARREADY  in  1 each  AR handshake
- AXI_RDATA  in  C_AXI_DATA_WIDTH  read data
- AXI_RRESP  in  2  read response
- AXI_RVALID / AXI_RREADY  in  1 each  R handshake
- ERR_CLEAR  in  1  clears ERR_STICKY, ERR_FIRST, ERR_FIRST_VALID
- ERR_PULSE  out  8  per-rule violation pulse
- ERR_STICKY  out  8  per-rule sticky flag
- ERR_FIRST  out  3  index of the first violation since reset/clear
- ERR_FIRST_VALID  out  1  ERR_FIRST holds a valid index
- OUTSTANDING  out  OW=$clog2(MAX_OUTSTANDING+1)  current outstanding reads
- RD_COUNT  out  32  completed R handshakes; wraps
- RESP_ERR_COUNT  out  16  R handshakes with RRESP[1]=1; saturates at 0xFFFF

## Operation
- Handshake definitions: arhs = ARVALID&ARREADY; rhs = RVALID&RREADY.
- The monitor registers the previous cycle's ARVALID, ARREADY, ARADDR, ARPROT, RVALID, RREADY, RDATA, RRESP and ARESETN. A "prev" rule applies only when ARESETN was high in both the previous and current cycles.
- Rule bits:
  - 0 AR_VALID_STABLE: prev ARVALID&!ARREADY, now !ARVALID.
  - 1 AR_PAYLOAD_STABLE: prev ARVALID&!ARREADY, now ARADDR or ARPROT differs.
  - 2 RVALID_RESET: RVALID high in the first cycle with ARESETN high after a low cycle.
  - 3 R_VALID_STABLE: prev RVALID&!RREADY, now !RVALID.
  - 4 R_PAYLOAD_STABLE: prev RVALID&!RREADY, now RDATA or RRESP differs.
  - 5 R_UNEXPECTED: rhs while OUTSTANDING==0, including when arhs occurs in the same cycle.
  - 6 OUTSTANDING_OVF: arhs while OUTSTANDING==MAX_OUTSTANDING and no rhs.
  - 7 RREADY_MAXWAIT: wait counter reaches MAXWAIT+1. The counter increments each cycle RVALID&!RREADY and clears on !RVALID or RREADY. Fires once per stall episode; the counter saturates at MAXWAIT+1.
- OUTSTANDING update: arhs&!rhs → +1, saturating at MAX_OUTSTANDING. rhs&!arhs → −1, saturating at 0. Both → unchanged, unless OUTSTANDING==0, in which case it goes to 1 (the R is unexpected, the AR is counted).
- RD_COUNT +1 per rhs, including unexpected ones. RESP_ERR_COUNT +1 per rhs with RRESP[1] (SLVERR/DECERR).
- ERR_STICKY |= ERR_PULSE each cycle.
- ERR_FIRST captures the lowest-numbered set pulse bit on the first cycle any pulse fires while ERR_FIRST_VALID=0, and then holds.
- ERR_CLEAR: ERR_STICKY ← this cycle's pulses and ERR_FIRST_VALID ← |pulses, with ERR_FIRST recaptured from them. New errors win over clear.
- While ARESETN is low, no rules are evaluated and no counting occurs.

## Timing
- Every output is registered. Inputs sampled at edge t are reflected in all outputs immediately after edge t, i.e. one-cycle latency.
- ERR_PULSE is high for exactly one cycle per detected violation.
- Reset (ARESETN low at an edge): all outputs, counters, wait counter and prev registers go to 0. The prev ARESETN register is set to 0.
- Reset asserted mid-transaction discards outstanding state. There are no errors for the interrupted transaction.
- The first edge with ARESETN high evaluates only rules 2, 5, 6 and 7. Rules 0, 1, 3 and 4 are skipped because the previous cycle was in reset.

## Test plan
- Clean traffic: 3 reads, each AR then R two cycles later with RREADY high → OUTSTANDING 1,0 pattern, RD_COUNT=3, ERR_STICKY=0x00.
- AR stall with ARADDR changing 0x10→0x14 while ARREADY is low → ERR_PULSE=0x02 for one cycle, ERR_FIRST=1, ERR_FIRST_VALID=1.
- RVALID high with RREADY low for 6 cycles, MAXWAIT=5 → ERR_PULSE[7] on the 6th stalled cycle only, then a single pulse; RDATA held stable, so no bit 4.
- R handshake with no outstanding AR → ERR_PULSE=0x20, RD_COUNT=1, OUTSTANDING=0. Next, 5 back-to-back ARs with no R and MAX_OUTSTANDING=4 → OUTSTANDING=4, ERR_PULSE[6] on the 5th.
- RVALID high on the first cycle after ARESETN rises → ERR_STICKY[2]=1. Then ERR_CLEAR in the same cycle as an RVALID drop during stall → ERR_STICKY=0x08, ERR_FIRST=3.
- Two R handshakes with RRESP=2'b10 and 2'b11, then a mid-transaction reset → RESP_ERR_COUNT=2, then all outputs 0 after the reset edge.

Source files
------------

// File: rtl/axi_rd_monitor.sv
// Passive AXI4-Lite read-path monitor: checks AR/R handshake rules and tracks outstanding reads.
// Each violation raises a pulse, a sticky bit and a first-error code; it also keeps completion and error-response counters.
module axi_rd_monitor #(
  parameter int MAXWAIT          = 5,
  parameter int MAX_OUTSTANDING  = 4,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 8,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESETN,
  input  logic [C_AXI_ADDR_WIDTH-1:0] AXI_ARADDR,
  input  logic [2:0]                  AXI_ARPROT,
  input  logic                        AXI_ARVALID,
  input  logic                        AXI_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0] AXI_RDATA,
  input  logic [1:0]                  AXI_RRESP,
  input  logic                        AXI_RVALID,
  input  logic                        AXI_RREADY,
  input  logic                        ERR_CLEAR,
  output logic [7:0]                  ERR_PULSE,
  output logic [7:0]                  ERR_STICKY,
  output logic [2:0]                  ERR_FIRST,
  output logic                        ERR_FIRST_VALID,
  output logic [OW-1:0]               OUTSTANDING,
  output logic [31:0]                 RD_COUNT,
  output logic [15:0]                 RESP_ERR_COUNT
);

  localparam int WW = $clog2(MAXWAIT + 2);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAXWAIT + 1);
  localparam logic [WW-1:0] WAIT_PRE = WW'(MAXWAIT);
  localparam logic [OW-1:0] OUT_MAX  = OW'(MAX_OUTSTANDING);

  logic                        prev_aresetn;
  logic                        prev_arvalid;
  logic                        prev_arready;
  logic [C_AXI_ADDR_WIDTH-1:0] prev_araddr;
  logic [2:0]                  prev_arprot;
  logic                        prev_rvalid;
  logic                        prev_rready;
  logic [C_AXI_DATA_WIDTH-1:0] prev_rdata;
  logic [1:0]                  prev_rresp;
  logic [WW-1:0]               wait_cnt;

  logic          arhs;
  logic          rhs;
  logic          r_stall;
  logic          ar_held;
  logic          r_held;
  logic [7:0]    pulse_c;
  logic [WW-1:0] wait_next;
  logic [OW-1:0] out_next;

  function automatic logic [2:0] lowest_idx(input logic [7:0] v);
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  // Rule evaluation; the always_ff reset branch discards everything while ARESETN is low.
  always_comb begin
    arhs    = AXI_ARVALID & AXI_ARREADY;
    rhs     = AXI_RVALID & AXI_RREADY;
    r_stall = AXI_RVALID & ~AXI_RREADY;
    ar_held = prev_aresetn & prev_arvalid & ~prev_arready;
    r_held  = prev_aresetn & prev_rvalid & ~prev_rready;

    pulse_c    = 8'h00;
    pulse_c[0] = ar_held & ~AXI_ARVALID;
    pulse_c[1] = ar_held & ((AXI_ARADDR != prev_araddr) | (AXI_ARPROT != prev_arprot));
    pulse_c[2] = ~prev_aresetn & AXI_RVALID;
    pulse_c[3] = r_held & ~AXI_RVALID;
    pulse_c[4] = r_held & ((AXI_RDATA != prev_rdata) | (AXI_RRESP != prev_rresp));
    pulse_c[5] = rhs & (OUTSTANDING == '0);
    pulse_c[6] = arhs & ~rhs & (OUTSTANDING == OUT_MAX);
    pulse_c[7] = r_stall & (wait_cnt == WAIT_PRE);

    wait_next = '0;
    if (r_stall) wait_next = (wait_cnt == WAIT_LIM) ? WAIT_LIM : wait_cnt + 1'b1;

    // A simultaneous AR and R with nothing outstanding counts the AR only.
    out_next = OUTSTANDING;
    if (arhs && !rhs) begin
      if (OUTSTANDING != OUT_MAX) out_next = OUTSTANDING + 1'b1;
    end else if (rhs && !arhs) begin
      if (OUTSTANDING != '0) out_next = OUTSTANDING - 1'b1;
    end else if (arhs && rhs && OUTSTANDING == '0) begin
      out_next = OW'(1);
    end
  end

  always_ff @(posedge AXI_ACLK) begin
    if (!AXI_ARESETN) begin
      prev_aresetn    <= 1'b0;
      prev_arvalid    <= 1'b0;
      prev_arready    <= 1'b0;
      prev_araddr     <= '0;
      prev_arprot     <= '0;
      prev_rvalid     <= 1'b0;
      prev_rready     <= 1'b0;
      prev_rdata      <= '0;
      prev_rresp      <= '0;
      wait_cnt        <= '0;
      ERR_PULSE       <= '0;
      ERR_STICKY      <= '0;
      ERR_FIRST       <= '0;
      ERR_FIRST_VALID <= 1'b0;
      OUTSTANDING     <= '0;
      RD_COUNT        <= '0;
      RESP_ERR_COUNT  <= '0;
    end else begin
      prev_aresetn <= 1'b1;
      prev_arvalid <= AXI_ARVALID;
      prev_arready <= AXI_ARREADY;
      prev_araddr  <= AXI_ARADDR;
      prev_arprot  <= AXI_ARPROT;
      prev_rvalid  <= AXI_RVALID;
      prev_rready  <= AXI_RREADY;
      prev_rdata   <= AXI_RDATA;
      prev_rresp   <= AXI_RRESP;
      wait_cnt     <= wait_next;
      ERR_PULSE    <= pulse_c;
      OUTSTANDING  <= out_next;

      // Clear drops history but keeps whatever fires in the same cycle.
      if (ERR_CLEAR) begin
        ERR_STICKY      <= pulse_c;
        ERR_FIRST_VALID <= |pulse_c;
        ERR_FIRST       <= lowest_idx(pulse_c);
      end else begin
        ERR_STICKY <= ERR_STICKY | pulse_c;
        if (!ERR_FIRST_VALID && |pulse_c) begin
          ERR_FIRST_VALID <= 1'b1;
          ERR_FIRST       <= lowest_idx(pulse_c);
        end
      end

      if (rhs) begin
        RD_COUNT <= RD_COUNT + 32'd1;
        if (AXI_RRESP[1] && RESP_ERR_COUNT != 16'hFFFF) RESP_ERR_COUNT <= RESP_ERR_COUNT + 16'd1;
      end
    end
  end

endmodule
